// File: rtl/vx_tag_access_assoc.sv
// rtl/vx_tag_access_assoc.sv - N-way set-associative tag store with round-robin fill victims
// Walks every set to clear it after reset and on flush; responses are registered one cycle after accept.
module vx_tag_access_assoc #(
    parameter int NUM_SETS    = 4,
    parameter int NUM_WAYS    = 2,
    parameter int LINE_ADDR_W = 8,
    parameter int SET_BITS    = $clog2(NUM_SETS),
    parameter int TAG_W       = LINE_ADDR_W - SET_BITS,
    parameter int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_all_i,
    output logic                   flush_busy_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [LINE_ADDR_W-1:0] req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_hit_o,
    output logic [NUM_WAYS-1:0]    rsp_way_o,
    output logic                   rsp_evict_o,
    output logic [TAG_W-1:0]       rsp_evict_tag_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(NUM_WAYS - 1);

    state_t                             state_q;
    logic [SET_BITS-1:0]                walk_cnt_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q;
    logic [TAG_W-1:0]                   tag_q [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0][WAY_BITS-1:0]  rr_q;

    logic [SET_BITS-1:0] req_set;
    logic [TAG_W-1:0]    req_tag;
    logic                accept;
    logic                walking;
    logic                is_fill;
    logic                is_inval;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [WAY_BITS-1:0] hit_idx;
    logic [WAY_BITS-1:0] inv_idx;
    logic                any_hit;
    logic                any_inv;
    logic [WAY_BITS-1:0] rr_cur;
    logic [WAY_BITS-1:0] rr_next;
    logic [WAY_BITS-1:0] wr_idx;
    logic [NUM_WAYS-1:0] wr_oh;
    logic                do_evict;
    logic [TAG_W-1:0]    victim_tag;

    assign req_set  = req_addr_i[SET_BITS-1:0];
    assign req_tag  = req_addr_i[LINE_ADDR_W-1:SET_BITS];
    assign walking  = (state_q != ST_IDLE);
    assign is_fill  = (req_op_i == 2'd1);
    assign is_inval = (req_op_i == 2'd2);

    assign req_ready_o = (state_q == ST_IDLE) && !flush_all_i && (!rsp_valid_o || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    // Descending scan so the lowest-index match wins for both encoders.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        inv_idx = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
            if (hit_vec[w]) begin
                hit_idx = WAY_BITS'(w);
            end
            if (!valid_q[req_set][w]) begin
                inv_idx = WAY_BITS'(w);
            end
        end
    end

    assign any_hit    = |hit_vec;
    assign any_inv    = ~&valid_q[req_set];
    assign rr_cur     = rr_q[req_set];
    assign rr_next    = (rr_cur == LAST_WAY) ? '0 : rr_cur + 1'b1;
    assign do_evict   = is_fill && !any_hit && !any_inv;
    assign wr_idx     = any_hit ? hit_idx : (any_inv ? inv_idx : rr_cur);
    assign wr_oh      = NUM_WAYS'(1) << wr_idx;
    assign victim_tag = tag_q[req_set][rr_cur];

    // Arrays carry no reset: the INIT walk clears the valid bits before any access.
    always_ff @(posedge clk_i) begin
        if (walking) begin
            valid_q[walk_cnt_q] <= '0;
        end else if (accept) begin
            if (is_fill) begin
                valid_q[req_set][wr_idx] <= 1'b1;
                tag_q[req_set][wr_idx]   <= req_tag;
            end else if (is_inval && any_hit) begin
                valid_q[req_set][hit_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_INIT;
            walk_cnt_q      <= '0;
            flush_busy_o    <= 1'b1;
            rr_q            <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_hit_o       <= 1'b0;
            rsp_way_o       <= '0;
            rsp_evict_o     <= 1'b0;
            rsp_evict_tag_o <= '0;
        end else begin
            case (state_q)
                ST_INIT, ST_FLUSH: begin
                    rr_q[walk_cnt_q] <= '0;
                    if (walk_cnt_q == LAST_SET) begin
                        state_q      <= ST_IDLE;
                        flush_busy_o <= 1'b0;
                        walk_cnt_q   <= '0;
                    end else begin
                        walk_cnt_q <= walk_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush_all_i) begin
                        state_q      <= ST_FLUSH;
                        flush_busy_o <= 1'b1;
                        walk_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_INIT;
                    flush_busy_o <= 1'b1;
                    walk_cnt_q   <= '0;
                end
            endcase

            if (accept && do_evict) begin
                rr_q[req_set] <= rr_next;
            end

            // A pending response is held until consumed; the walk runs alongside it.
            if (accept) begin
                rsp_valid_o <= 1'b1;
                rsp_hit_o   <= any_hit;
                if (is_fill) begin
                    rsp_way_o       <= wr_oh;
                    rsp_evict_o     <= do_evict;
                    rsp_evict_tag_o <= do_evict ? victim_tag : '0;
                end else begin
                    rsp_way_o       <= hit_vec;
                    rsp_evict_o     <= 1'b0;
                    rsp_evict_tag_o <= '0;
                end
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule
